d_m_areg_queue: RTL and testbench

- Parametrised successor to the single-entry directory-to-memory address/flit register.
- Buffers up to DEPTH request flit groups from the directory (d) side and presents the oldest to the memory (m) side.
- Pops on mem_done_access.
- Lets the directory issue back-to-back requests while memory is busy, instead of stalling after one.

---
 rtl/d_m_areg_pkg.sv | 16 +
 rtl/d_m_areg_mem.sv | 28 ++
 rtl/d_m_areg_queue.sv | 122 ++++++++++++
 tb/tb_d_m_areg_queue.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/d_m_areg_pkg.sv
// d_m_areg_pkg: shared defaults and width helpers for the directory-to-memory
// request queue (d_m_areg_queue and its storage sub-module).
package d_m_areg_pkg;

  localparam int D_M_IN_W  = 144;
  localparam int D_M_OUT_W = 176;
  localparam int D_M_DEPTH = 4;

  // Zero-extension pad width from an IN_W entry to an OUT_W flit group.
  // A non-positive result means no padding is required (or the widths are
  // misconfigured with OUT_W < IN_W, which callers treat as no padding).
  function automatic int zext_pad_w(input int in_w, input int out_w);
    return (out_w > in_w) ? (out_w - in_w) : 0;
  endfunction

endpackage

// File: rtl/d_m_areg_mem.sv
// d_m_areg_mem: DEPTH x IN_W register array backing the request queue.
// Synchronous write, asynchronous read, no reset on the storage itself.
module d_m_areg_mem
  import d_m_areg_pkg::*;
#(
  parameter int IN_W  = D_M_IN_W,
  parameter int DEPTH = D_M_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [IN_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [IN_W-1:0]          rdata
);

  logic [IN_W-1:0] mem [DEPTH];

  // Write the pushed flit group into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/d_m_areg_queue.sv
// d_m_areg_queue: DEPTH-entry FIFO between directory and memory. Holds request
// flit groups and presents the oldest, zero-extended to OUT_W, until memory
// signals mem_done_access. Optional macro D_M_AREG_PERF_EN adds a saturating
// count of cycles spent full on d_m_areg_full_cycles.
module d_m_areg_queue
  import d_m_areg_pkg::*;
#(
  parameter int IN_W  = D_M_IN_W,
  parameter int OUT_W = D_M_OUT_W,
  parameter int DEPTH = D_M_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_W-1:0]          d_flits_m,
  input  logic                     v_d_flits_m,
  input  logic                     mem_done_access,
  output logic [OUT_W-1:0]         d_m_areg_flits,
  output logic                     v_d_m_areg_flits,
  output logic                     d_m_areg_state,
  output logic [$clog2(DEPTH):0]   d_m_areg_count,
  output logic                     d_m_areg_ovf
`ifdef D_M_AREG_PERF_EN
  ,
  output logic [15:0]              d_m_areg_full_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PAD_W = zext_pad_w(IN_W, OUT_W);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             full;
  logic             not_empty;
  logic             pop;
  logic             push;
  logic [IN_W-1:0]  head;
  logic [OUT_W-1:0] head_ext;

  assign full      = (count == CNT_FULL);
  assign not_empty = (count != '0);

  // A pop frees the head slot in the same cycle, so a full queue may still
  // take a push alongside it. A pop on an empty queue is simply ignored.
  assign pop  = mem_done_access && not_empty;
  assign push = v_d_flits_m && (!full || pop);

  d_m_areg_mem #(
    .IN_W  (IN_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (d_flits_m),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (v_d_flits_m && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

  generate
    if (PAD_W > 0) begin : g_zext
      assign head_ext = {{PAD_W{1'b0}}, head};
    end else begin : g_nozext
      assign head_ext = head;
    end
  endgenerate

  // Outputs decode registered count only; the gate keeps stale storage hidden
  // while empty, including the instant reset asserts.
  assign d_m_areg_flits   = not_empty ? head_ext : '0;
  assign v_d_m_areg_flits = not_empty;
  assign d_m_areg_state   = full;
  assign d_m_areg_count   = count;
  assign d_m_areg_ovf     = ovf;

`ifdef D_M_AREG_PERF_EN
  logic [15:0] full_cycles;

  // Saturating count of clock edges observed with the queue full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_cycles <= '0;
    end else if (full && (full_cycles != 16'hFFFF)) begin
      full_cycles <= full_cycles + 16'd1;
    end
  end

  assign d_m_areg_full_cycles = full_cycles;
`endif

endmodule

// File: tb/tb_d_m_areg_queue.sv
// tb_d_m_areg_queue: directed and randomized checks of d_m_areg_queue against
// a queue-based reference model of the request buffer.
module tb_d_m_areg_queue;

  localparam int IN_W  = 144;
  localparam int OUT_W = 176;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [IN_W-1:0]   d_flits_m;
  logic              v_d_flits_m;
  logic              mem_done_access;
  logic [OUT_W-1:0]  d_m_areg_flits;
  logic              v_d_m_areg_flits;
  logic              d_m_areg_state;
  logic [CNT_W-1:0]  d_m_areg_count;
  logic              d_m_areg_ovf;
`ifdef D_M_AREG_PERF_EN
  logic [15:0]       d_m_areg_full_cycles;
  int                model_full;
`endif

  always #5 clk = ~clk;

  d_m_areg_queue #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .d_flits_m        (d_flits_m),
    .v_d_flits_m      (v_d_flits_m),
    .mem_done_access  (mem_done_access),
    .d_m_areg_flits   (d_m_areg_flits),
    .v_d_m_areg_flits (v_d_m_areg_flits),
    .d_m_areg_state   (d_m_areg_state),
    .d_m_areg_count   (d_m_areg_count),
    .d_m_areg_ovf     (d_m_areg_ovf)
`ifdef D_M_AREG_PERF_EN
    ,
    .d_m_areg_full_cycles (d_m_areg_full_cycles)
`endif
  );

  int checks = 0;
  int failures = 0;
  int txn = 0;
  logic [IN_W-1:0] model_q[$];
  logic            model_ovf = 1'b0;

  task automatic check_val(input string tag, input logic [OUT_W-1:0] got,
                           input logic [OUT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare every output against the reference model.
  task automatic check_outputs(input string tag);
    logic [OUT_W-1:0] exp_head;
    exp_head = (model_q.size() != 0) ? OUT_W'(model_q[0]) : '0;
    check_val({tag, "_flits"}, d_m_areg_flits, exp_head);
    check_val({tag, "_valid"}, OUT_W'(v_d_m_areg_flits), OUT_W'(model_q.size() != 0));
    check_val({tag, "_count"}, OUT_W'(d_m_areg_count), OUT_W'(model_q.size()));
    check_val({tag, "_state"}, OUT_W'(d_m_areg_state), OUT_W'(model_q.size() == DEPTH));
    check_val({tag, "_ovf"}, OUT_W'(d_m_areg_ovf), OUT_W'(model_ovf));
`ifdef D_M_AREG_PERF_EN
    check_val({tag, "_fullcyc"}, OUT_W'(d_m_areg_full_cycles), OUT_W'(model_full));
`endif
  endtask

  // One clock of stimulus; model updated from the pre-edge occupancy.
  task automatic step(input string tag, input bit push, input logic [IN_W-1:0] data,
                      input bit pop);
    int  sz;
    bit  pop_ok;
    bit  push_ok;
    v_d_flits_m     = push;
    d_flits_m       = data;
    mem_done_access = pop;
    @(posedge clk);
    sz      = model_q.size();
    pop_ok  = pop && (sz > 0);
    push_ok = push && ((sz < DEPTH) || pop_ok);
    if (push && !push_ok) model_ovf = 1'b1;
`ifdef D_M_AREG_PERF_EN
    if ((sz == DEPTH) && (model_full < 65535)) model_full++;
`endif
    if (pop_ok) void'(model_q.pop_front());
    if (push_ok) model_q.push_back(data);
    txn++;
    $display("txn %0d %s push=%0b pop=%0b data=%0h occ=%0d", txn, tag, push, pop,
             data, model_q.size());
    @(negedge clk);
    check_outputs(tag);
  endtask

  function automatic logic [IN_W-1:0] rand_flits();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[IN_W-1:0];
  endfunction

  initial begin
    rst = 1'b0;
    d_flits_m = '0;
    v_d_flits_m = 1'b0;
    mem_done_access = 1'b0;
`ifdef D_M_AREG_PERF_EN
    model_full = 0;
`endif
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 1'b1;

    // Single push into empty queue: visible next cycle.
    step("idle", 1'b0, '0, 1'b0);
    step("push_a5", 1'b1, IN_W'(144'hA5), 1'b0);
    check_val("a5_flits", d_m_areg_flits, OUT_W'(176'hA5));
    step("drain_a5", 1'b0, '0, 1'b1);

    // Full queue with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) step("fill", 1'b1, IN_W'(i), 1'b0);
    check_val("full_state", OUT_W'(d_m_areg_state), OUT_W'(1));
    step("full_pushpop", 1'b1, IN_W'(9), 1'b1);
    check_val("pp_count", OUT_W'(d_m_areg_count), OUT_W'(4));
    check_val("pp_ovf", OUT_W'(d_m_areg_ovf), OUT_W'(0));
    check_val("pp_head", d_m_areg_flits, OUT_W'(2));
    for (int i = 0; i < 3; i++) step("pp_pop", 1'b0, '0, 1'b1);
    check_val("pp_last9", d_m_areg_flits, OUT_W'(9));
    step("pp_pop", 1'b0, '0, 1'b1);

    // Overflow: fifth push while full without pop.
    for (int i = 1; i <= 4; i++) step("fill", 1'b1, IN_W'(i), 1'b0);
    step("ovf_push5", 1'b1, IN_W'(5), 1'b0);
    check_val("ovf_set", OUT_W'(d_m_areg_ovf), OUT_W'(1));
    check_val("ovf_count", OUT_W'(d_m_areg_count), OUT_W'(4));
    for (int i = 1; i <= 4; i++) begin
      check_val("ovf_order", d_m_areg_flits, OUT_W'(i));
      step("ovf_pop", 1'b0, '0, 1'b1);
    end
    check_val("ovf_drained_v", OUT_W'(v_d_m_areg_flits), OUT_W'(0));

    // Pop on empty is ignored.
    step("empty_pop", 1'b0, '0, 1'b1);
    check_val("empty_flits", d_m_areg_flits, '0);

    // Wrap-around at occupancy 1-2.
    step("wrap", 1'b1, IN_W'(8'h10), 1'b0);
    for (int i = 1; i < 10; i++) step("wrap", 1'b1, IN_W'(8'h10 + i), 1'b1);
    check_val("wrap_last", d_m_areg_flits, OUT_W'(8'h19));
    step("wrap_drain", 1'b0, '0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 9) < 6), rand_flits(), ($urandom_range(0, 9) < 5));
    end
    while (model_q.size() > 0) step("rand_drain", 1'b0, '0, 1'b1);

    // Asynchronous reset mid-cycle with three entries held.
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, rand_flits(), 1'b0);
    v_d_flits_m = 1'b0;
    mem_done_access = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
`ifdef D_M_AREG_PERF_EN
    model_full = 0;
`endif
    check_outputs("async_rst");
    check_val("async_rst_flits", d_m_areg_flits, '0);
    @(negedge clk);
    rst = 1'b1;

`ifdef D_M_AREG_PERF_EN
    for (int i = 1; i <= 4; i++) step("perf_fill", 1'b1, IN_W'(i), 1'b0);
    for (int i = 0; i < 20; i++) step("perf_hold", 1'b0, '0, 1'b0);
    check_val("perf_full20", OUT_W'(d_m_areg_full_cycles), OUT_W'(20));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
